// File: rtl/mux_sel_arbiter_if.sv
// Request/grant bundle between the channel writers, the arbiter and the
// registered mux stage it feeds.
interface mux_sel_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int DW     = 8
) ();
    localparam int SEL_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0]    req_valid;
    logic [NUM_CH*DW-1:0] req_data;
    logic [NUM_CH-1:0]    req_ready;
    logic [NUM_CH*DW-1:0] in;
    logic [SEL_W-1:0]     s;
    logic                 sel_valid;
    logic                 sel_ready;

    modport master (
        output req_valid,
        output req_data,
        output sel_ready,
        input  req_ready,
        input  in,
        input  s,
        input  sel_valid
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  sel_ready,
        output req_ready,
        output in,
        output s,
        output sel_valid
    );
endinterface

// File: rtl/mux_sel_arbiter.sv
// One-word buffer per channel, round-robin grant onto the mux select;
// the select is held until the mux output consumer takes it.
module mux_sel_arbiter #(
    parameter int NUM_CH = 4,
    parameter int DW     = 8
) (
    input  logic             clk,
    input  logic             rst,
    mux_sel_arbiter_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_CH);

    typedef enum logic {IDLE, GRANT} state_e;

    state_e               state_q, state_d;
    logic [NUM_CH-1:0]    full_q, full_d;
    logic [NUM_CH*DW-1:0] buf_q, buf_d;
    logic [SEL_W-1:0]     s_q, s_d;
    logic [SEL_W-1:0]     ptr_q, ptr_d;
    logic                 sel_valid_q, sel_valid_d;
    logic [SEL_W-1:0]     winner;
    logic [SEL_W-1:0]     idx;

    // Scan downward so the candidate closest to ptr is the last one written.
    always_comb begin
        winner = '0;
        idx    = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = ptr_q + SEL_W'(k);
            if (full_q[idx]) winner = idx;
        end
    end

    always_comb begin
        state_d     = state_q;
        full_d      = full_q;
        buf_d       = buf_q;
        s_d         = s_q;
        ptr_d       = ptr_q;
        sel_valid_d = sel_valid_q;

        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.req_valid[i] && !full_q[i]) begin
                full_d[i]          = 1'b1;
                buf_d[i*DW +: DW]  = bus.req_data[i*DW +: DW];
            end
        end

        unique case (state_q)
            IDLE: begin
                if (|full_q) begin
                    s_d         = winner;
                    sel_valid_d = 1'b1;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                if (bus.sel_ready) begin
                    full_d[s_q] = 1'b0;
                    sel_valid_d = 1'b0;
                    ptr_d       = s_q + SEL_W'(1);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            full_q      <= '0;
            buf_q       <= '0;
            s_q         <= '0;
            ptr_q       <= '0;
            sel_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            full_q      <= full_d;
            buf_q       <= buf_d;
            s_q         <= s_d;
            ptr_q       <= ptr_d;
            sel_valid_q <= sel_valid_d;
        end
    end

    assign bus.req_ready = ~full_q;
    assign bus.in        = buf_q;
    assign bus.s         = s_q;
    assign bus.sel_valid = sel_valid_q;
endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Bench for mux_sel_arbiter: per-cycle compare against a channel-level
// model plus directed scenarios with literal expectations.
module tb_mux_sel_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mux_sel_arbiter_if #(.NUM_CH(N), .DW(DW)) bus ();

    mux_sel_arbiter #(.NUM_CH(N), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Model: which channels hold a word, what it is, the rotation
    // start point and the channel currently offered (-1 when none).
    bit            m_full [N];
    logic [DW-1:0] m_buf  [N];
    int            m_ptr;
    int            m_gnt;
    int            cyc = 0;
    int            glog [$];
    int            gdat [$];
    int            gcyc [$];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                m_full[i] <= 1'b0;
                m_buf[i]  <= '0;
            end
            m_ptr <= 0;
            m_gnt <= -1;
        end else begin : step
            bit            nf [N];
            logic [DW-1:0] nb [N];
            int            np;
            int            ng;
            nf = m_full;
            nb = m_buf;
            np = m_ptr;
            ng = m_gnt;
            for (int i = 0; i < N; i++) begin
                if (bus.req_valid[i] && !m_full[i]) begin
                    nf[i] = 1'b1;
                    nb[i] = bus.req_data[i*DW +: DW];
                end
            end
            if (m_gnt >= 0) begin
                if (bus.sel_ready) begin
                    nf[m_gnt] = 1'b0;
                    np = (m_gnt + 1) % N;
                    ng = -1;
                end
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (ng < 0 && m_full[(m_ptr + k) % N]) begin
                        ng = (m_ptr + k) % N;
                        glog.push_back(ng);
                        gdat.push_back(int'(m_buf[ng]));
                        gcyc.push_back(cyc);
                    end
                end
            end
            m_full <= nf;
            m_buf  <= nb;
            m_ptr  <= np;
            m_gnt  <= ng;
            cyc    <= cyc + 1;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic compare_cycle();
        logic [N-1:0]    e_rdy;
        logic [N*DW-1:0] e_in;
        for (int i = 0; i < N; i++) begin
            e_rdy[i]         = ~m_full[i];
            e_in[i*DW +: DW] = m_buf[i];
        end
        chk("sel_valid", 32'(bus.sel_valid), 32'(m_gnt >= 0));
        chk("req_ready", 32'(bus.req_ready), 32'(e_rdy));
        chk("in", 32'(bus.in), 32'(e_in));
        if (m_gnt >= 0) chk("s", 32'(bus.s), m_gnt);
    endtask

    int base;
    int exp_t4 [4] = '{0, 1, 2, 3};
    int dat_t4 [4] = '{'h11, 'h22, 'h33, 'h44};
    int exp_t5 [4] = '{0, 3, 0, 3};
    int exp_t6 [3] = '{2, 3, 1};

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.sel_ready = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (rst) compare_cycle();
            end
        join_none

        #12;
        chk("rst_valid", 32'(bus.sel_valid), 0);
        chk("rst_ready", 32'(bus.req_ready), 'hf);
        chk("rst_in", bus.in, 0);
        @(posedge clk);
        #2 rst = 1'b1;

        // single word on ch2
        bus.sel_ready = 1'b1;
        tick(1);
        bus.req_valid[2] = 1'b1;
        bus.req_data[23:16] = 8'hA5;
        tick(1);
        bus.req_valid = '0;
        tick(1);
        chk("t2_valid", 32'(bus.sel_valid), 1);
        chk("t2_s", 32'(bus.s), 2);
        chk("t2_in", 32'(bus.in[23:16]), 'hA5);
        chk("t2_busy", 32'(bus.req_ready[2]), 0);
        tick(1);
        chk("t2_done", 32'(bus.sel_valid), 0);
        chk("t2_free", 32'(bus.req_ready[2]), 1);

        // backpressure on ch1
        bus.sel_ready = 1'b0;
        bus.req_valid[1] = 1'b1;
        bus.req_data[15:8] = 8'h3C;
        tick(1);
        bus.req_valid = '0;
        tick(1);
        chk("t3_valid", 32'(bus.sel_valid), 1);
        chk("t3_s", 32'(bus.s), 1);
        bus.req_valid[1] = 1'b1;
        bus.req_data[15:8] = 8'h55;
        tick(1);
        bus.req_valid = '0;
        chk("t3_ready", 32'(bus.req_ready[1]), 0);
        tick(3);
        chk("t3_hold_v", 32'(bus.sel_valid), 1);
        chk("t3_hold_s", 32'(bus.s), 1);
        chk("t3_hold_in", 32'(bus.in[15:8]), 'h3C);
        bus.sel_ready = 1'b1;
        tick(1);
        chk("t3_done", 32'(bus.sel_valid), 0);
        tick(1);

        // async reset while a grant is pending
        bus.sel_ready = 1'b0;
        bus.req_valid[0] = 1'b1;
        bus.req_data[7:0] = 8'h77;
        tick(1);
        bus.req_valid = '0;
        tick(1);
        chk("t1_pre", 32'(bus.sel_valid), 1);
        #1 rst = 1'b0;
        #1;
        chk("t1_valid", 32'(bus.sel_valid), 0);
        chk("t1_s", 32'(bus.s), 0);
        chk("t1_in", bus.in, 0);
        chk("t1_ready", 32'(bus.req_ready), 'hf);
        tick(1);
        rst = 1'b1;

        // all channels at once
        bus.sel_ready = 1'b1;
        base = glog.size();
        bus.req_valid = 4'hf;
        bus.req_data  = 32'h44332211;
        tick(1);
        bus.req_valid = '0;
        tick(10);
        chk("t4_cnt", glog.size() - base, 4);
        for (int k = 0; k < 4; k++) begin
            chk("t4_ch", glog[base+k], exp_t4[k]);
            chk("t4_data", gdat[base+k], dat_t4[k]);
            if (k > 0) chk("t4_gap", gcyc[base+k] - gcyc[base+k-1], 2);
        end

        // ch0 refilled continuously, ch3 kept full
        base = glog.size();
        bus.req_valid = 4'b1001;
        bus.req_data  = 32'h53000050;
        tick(9);
        bus.req_valid = '0;
        tick(10);
        chk("t5_cnt", 32'(glog.size() - base >= 4), 1);
        for (int k = 0; k < 4; k++) chk("t5_ch", glog[base+k], exp_t5[k]);

        // pointer wrap after serving ch2
        bus.sel_ready = 1'b0;
        base = glog.size();
        bus.req_valid[2] = 1'b1;
        bus.req_data[23:16] = 8'h62;
        tick(1);
        bus.req_valid = '0;
        tick(1);
        bus.req_valid = 4'b1010;
        bus.req_data  = 32'h63006100;
        tick(1);
        bus.req_valid = '0;
        bus.sel_ready = 1'b1;
        tick(8);
        chk("t6_cnt", glog.size() - base, 3);
        for (int k = 0; k < 3; k++) chk("t6_ch", glog[base+k], exp_t6[k]);
        chk("t6_idle", 32'(bus.sel_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
